// File: rtl/bp_pkg.sv
// bp_pkg: shared entry layout, counter constants and PC index/tag split for bht_btb_predictor.
package bp_pkg;
   localparam int BP_N = 32;
   localparam int BP_ENTRIES = 16;
   localparam int BP_CTR_W = 2;
   localparam int BP_IDX_W = $clog2(BP_ENTRIES);
   localparam int BP_TAG_W = BP_N - BP_IDX_W;
   localparam logic [BP_CTR_W-1:0] CTR_RST = {1'b0, {(BP_CTR_W-1){1'b1}}};
   localparam logic [BP_CTR_W-1:0] CTR_ALLOC = {1'b1, {(BP_CTR_W-1){1'b0}}};

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_N-1:0]     target;
      logic [BP_CTR_W-1:0] ctr;
   } entry_t;

   typedef struct packed {
      logic [BP_TAG_W-1:0] tag;
      logic [BP_IDX_W-1:0] idx;
   } pc_split_t;

   // Tag sits above the index bits, so the split is a plain reinterpretation of the PC.
   function automatic pc_split_t bp_split(input logic [BP_N-1:0] pc);
      return pc;
   endfunction
endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: saturating up/down counter step (inc, dec, or hold when neither).
module bp_sat_ctr #(
   parameter int CTR_W = 2
) (
   input  logic             inc,
   input  logic             dec,
   input  logic [CTR_W-1:0] ctr_i,
   output logic [CTR_W-1:0] ctr_o
);
   localparam logic [CTR_W-1:0] ONE = 1;

   always_comb
      ctr_o = (inc && ctr_i != '1) ? ctr_i + ONE :
              (dec && ctr_i != '0) ? ctr_i - ONE : ctr_i;
endmodule

// File: rtl/bht_btb_predictor.sv
// bht_btb_predictor: direct-mapped BHT+BTB with zero-latency lookup and one-cycle update.
// Define BP_STATS_EN to add saturating lookup/mispredict statistics counters.
module bht_btb_predictor
   import bp_pkg::*;
#(
   parameter int N       = BP_N,
   parameter int ENTRIES = BP_ENTRIES,
   parameter int CTR_W   = BP_CTR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] lookup_pc,
   output logic         pred_hit,
   output logic         pred_taken,
   output logic [N-1:0] pred_target,
   input  logic         upd_valid,
   input  logic [N-1:0] upd_pc,
   input  logic         upd_taken,
   input  logic [N-1:0] upd_target,
   input  logic         flush,
`ifdef BP_STATS_EN
   output logic [31:0]  stat_lookups,
   output logic [31:0]  stat_mispredicts,
`endif
   output logic         upd_mispredict
);
   localparam logic [N-1:0] PC_ONE = 1;

   entry_t tbl_q [ENTRIES];
   entry_t tbl_d [ENTRIES];
   pc_split_t lk, up;
   entry_t le, ue, ne;
   logic u_hit, u_pred_taken;
   logic [N-1:0] u_pred_target;
   logic [CTR_W-1:0] ctr_nxt;

   always_comb begin
      lk = bp_split(lookup_pc);
      le = tbl_q[lk.idx];
      pred_hit = le.valid && le.tag == lk.tag;
      pred_taken = pred_hit && le.ctr[CTR_W-1];
      pred_target = pred_taken ? le.target : lookup_pc + PC_ONE;
   end

   // Same lookup rule applied to upd_pc against pre-update state.
   always_comb begin
      up = bp_split(upd_pc);
      ue = tbl_q[up.idx];
      u_hit = ue.valid && ue.tag == up.tag;
      u_pred_taken = u_hit && ue.ctr[CTR_W-1];
      u_pred_target = u_pred_taken ? ue.target : upd_pc + PC_ONE;
      upd_mispredict = upd_valid && (u_pred_taken != upd_taken ||
                       (upd_taken && u_pred_target != upd_target));
   end

   bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
      .inc  (upd_taken),
      .dec  (!upd_taken),
      .ctr_i(ue.ctr),
      .ctr_o(ctr_nxt)
   );

   always_comb begin
      ne = u_hit ? '{valid: 1'b1, tag: ue.tag, target: upd_taken ? upd_target : ue.target, ctr: ctr_nxt} :
           upd_taken ? '{valid: 1'b1, tag: up.tag, target: upd_target, ctr: CTR_ALLOC} : ue;
      tbl_d = tbl_q;
      if (flush)
         for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
      else if (upd_valid)
         tbl_d[up.idx] = ne;
   end

   always_ff @(posedge clk)
      if (rst)
         for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RST};
      else
         tbl_q <= tbl_d;

`ifdef BP_STATS_EN
   logic [31:0] stat_lookups_q, stat_lookups_d, stat_mispredicts_q, stat_mispredicts_d;

   always_comb begin
      stat_lookups_d = (&stat_lookups_q) ? stat_lookups_q : stat_lookups_q + 32'd1;
      stat_mispredicts_d = (upd_mispredict && !(&stat_mispredicts_q)) ? stat_mispredicts_q + 32'd1 : stat_mispredicts_q;
   end

   always_ff @(posedge clk)
      if (rst) begin
         stat_lookups_q <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_lookups_q <= stat_lookups_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end

   assign stat_lookups = stat_lookups_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_bht_btb_predictor.sv
// tb_bht_btb_predictor: directed self-checking bench for bht_btb_predictor (N=32, ENTRIES=16, CTR_W=2).
module tb_bht_btb_predictor;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] lookup_pc = '0;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        flush = 1'b0;
   logic        upd_mispredict;
   int          errors = 0;
   int          checks = 0;
`ifdef BP_STATS_EN
   logic [31:0] stat_lookups, stat_mispredicts;
`endif

   bht_btb_predictor #(.N(32), .ENTRIES(16), .CTR_W(2)) dut (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .flush(flush),
`ifdef BP_STATS_EN
      .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts),
`endif
      .upd_mispredict(upd_mispredict)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
      upd_valid = v;
      upd_pc = pc;
      upd_taken = t;
      upd_target = tgt;
   endtask

   task automatic look(input string name, input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tgt);
      lookup_pc = pc;
      #1;
      checks++;
      if ({pred_hit, pred_taken, pred_target} !== {h, t, tgt}) begin
         errors++;
         $display("FAIL %s: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                  name, pred_hit, pred_taken, pred_target, h, t, tgt);
      end
   endtask

   task automatic chk_misp(input string name, input logic exp);
      #1;
      checks++;
      if (upd_mispredict !== exp) begin
         errors++;
         $display("FAIL %s: upd_mispredict got %0b want %0b", name, upd_mispredict, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_upd(1'b1, 32'h40, 1'b1, 32'h10);
      tick();
      tick();
      look("reset_during", 32'h40, 1'b0, 1'b0, 32'h41);
      rst = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      look("reset_after", 32'h40, 1'b0, 1'b0, 32'h41);
      chk_misp("reset_no_upd", 1'b0);
   endtask

   task automatic test_alloc();
      set_upd(1'b1, 32'h40, 1'b1, 32'h10);
      look("alloc_same_cycle_pre", 32'h40, 1'b0, 1'b0, 32'h41);
      chk_misp("alloc_misp", 1'b1);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      look("alloc_hit", 32'h40, 1'b1, 1'b1, 32'h10);
   endtask

   task automatic test_counter();
      set_upd(1'b1, 32'h40, 1'b0, 32'h0);
      chk_misp("ctr_nt1_misp", 1'b1);
      tick();
      look("ctr_01", 32'h40, 1'b1, 1'b0, 32'h41);
      chk_misp("ctr_nt2_misp", 1'b0);
      tick();
      tick();
      look("ctr_00_sat", 32'h40, 1'b1, 1'b0, 32'h41);
      set_upd(1'b1, 32'h40, 1'b1, 32'h10);
      chk_misp("ctr_t_from0_misp", 1'b1);
      tick();
      look("ctr_01_up", 32'h40, 1'b1, 1'b0, 32'h41);
      set_upd(1'b1, 32'h40, 1'b1, 32'h33);
      tick();
      look("ctr_10_target", 32'h40, 1'b1, 1'b1, 32'h33);
      set_upd(1'b1, 32'h40, 1'b1, 32'h33);
      chk_misp("ctr_correct_misp", 1'b0);
      tick();
      set_upd(1'b1, 32'h40, 1'b1, 32'h44);
      chk_misp("ctr_target_misp", 1'b1);
      tick();
      set_upd(1'b1, 32'h40, 1'b0, 32'h0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      look("ctr_11_sat_then_10", 32'h40, 1'b1, 1'b1, 32'h44);
   endtask

   task automatic test_alias();
      set_upd(1'b1, 32'h50, 1'b1, 32'h20);
      chk_misp("alias_alloc_misp", 1'b1);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      look("alias_50_hit", 32'h50, 1'b1, 1'b1, 32'h20);
      look("alias_40_miss", 32'h40, 1'b0, 1'b0, 32'h41);
      set_upd(1'b1, 32'h60, 1'b0, 32'h0);
      chk_misp("alias_nt_miss_misp", 1'b0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      look("alias_50_intact", 32'h50, 1'b1, 1'b1, 32'h20);
      look("alias_60_miss", 32'h60, 1'b0, 1'b0, 32'h61);
   endtask

   task automatic test_wrap();
      look("wrap_miss", 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
      set_upd(1'b1, 32'h1F, 1'b1, 32'h5);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      look("top_index_hit", 32'h1F, 1'b1, 1'b1, 32'h5);
      look("top_index_other_tag", 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_flush_reset();
      set_upd(1'b1, 32'h70, 1'b1, 32'h99);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      look("flush_70_miss", 32'h70, 1'b0, 1'b0, 32'h71);
      look("flush_50_miss", 32'h50, 1'b0, 1'b0, 32'h51);
      look("flush_1f_miss", 32'h1F, 1'b0, 1'b0, 32'h20);
      set_upd(1'b1, 32'h30, 1'b1, 32'h77);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      look("rst_drops_upd", 32'h30, 1'b0, 1'b0, 32'h31);
   endtask

`ifdef BP_STATS_EN
   task automatic test_stats();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_upd(1'b1, 32'h40, 1'b1, 32'h10);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      repeat (4) tick();
      checks++;
      if ({stat_lookups, stat_mispredicts} !== {32'd5, 32'd1}) begin
         errors++;
         $display("FAIL stats_count: got lookups=%0d misp=%0d want 5 1", stat_lookups, stat_mispredicts);
      end
      force dut.stat_lookups_q = 32'hFFFF_FFFF;
      force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
      #1;
      release dut.stat_lookups_q;
      release dut.stat_mispredicts_q;
      set_upd(1'b1, 32'h20, 1'b1, 32'h1);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      checks++;
      if ({stat_lookups, stat_mispredicts} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
         errors++;
         $display("FAIL stats_sat: got lookups=%h misp=%h want ffffffff ffffffff", stat_lookups, stat_mispredicts);
      end
   endtask
`endif

   initial begin
      #1;
      test_reset();
      test_alloc();
      test_counter();
      test_alias();
      test_wrap();
      test_flush_reset();
`ifdef BP_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bht_btb_predictor.md
BHT_BTB_PREDICTOR -- requirements
Module: bht_btb_predictor

Interface
REQ-001 SHALL have parameter N, default 32: PC/target width (word-addressed PC, sequential PC = pc+1).
REQ-002 SHALL have parameter ENTRIES, default 16: table depth, power of two >= 2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CTR_W, default 2: saturating-counter width, >= 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports clk and rst as below.
REQ-005 Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- lookup_pc  in  N  IF-stage PC
- pred_hit  out  1  valid tag match for lookup_pc
- pred_taken  out  1  predict taken
- pred_target  out  N  next-PC prediction
- upd_valid  in  1  resolved branch this cycle
- upd_pc  in  N  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  N  actual taken target
- flush  in  1  invalidate whole table
- upd_mispredict  out  1  combinational: table state mispredicted upd_pc

Function
REQ-006 Index = pc[IDX_W-1:0]; tag = pc[N-1:IDX_W]; each entry holds valid, tag, target[N-1:0], ctr[CTR_W-1:0].
REQ-007 Lookup SHALL be combinational, zero latency: pred_hit = valid && tag match; pred_taken = pred_hit && ctr MSB; pred_target = pred_taken ? target : lookup_pc+1 (wraps modulo 2^N).
REQ-008 Update (upd_valid=1) SHALL write on the clk edge, one cycle latency to lookup visibility.
REQ-009 Update, hit: ctr increments if upd_taken, decrements otherwise, saturating at all-ones and zero; target overwritten with upd_target only when upd_taken.
REQ-010 Update, miss and upd_taken=1: allocate (replace any occupant): valid=1, tag, target=upd_target, ctr=2^(CTR_W-1) (weakly taken).
REQ-011 Update, miss and upd_taken=0: table SHALL be unchanged.
REQ-012 upd_mispredict = upd_valid && (predicted_taken(upd_pc) != upd_taken || (upd_taken && predicted_target(upd_pc) != upd_target)), predictions per REQ-007 on pre-update state.
REQ-013 Same-cycle lookup and update to the same index: lookup SHALL return pre-update contents.
REQ-014 flush=1: all valid bits cleared at the edge; counters/targets untouched; flush overrides a simultaneous update.

Reset
REQ-015 rst=1 at an edge: all valid=0, all ctr=2^(CTR_W-1)-1 (weakly not taken), targets/tags 0; overrides flush and update.
REQ-016 During and after reset, outputs follow REQ-007 on reset state: pred_hit=0, pred_taken=0, pred_target=lookup_pc+1.
REQ-017 Reset mid-operation SHALL discard any concurrent update; no partial entry write.

Configuration
REQ-018 Macro BP_STATS_EN defined: outputs stat_lookups[31:0] (increments each cycle not in reset) and stat_mispredicts[31:0] (increments when upd_mispredict=1), both saturating at 0xFFFFFFFF, reset to 0, not cleared by flush.
REQ-019 BP_STATS_EN undefined: stat ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-020 Shared package bp_pkg SHALL hold the entry struct typedef, counter reset/allocate constants, and index/tag extraction functions.
REQ-021 Saturating counter update SHALL be one sub-module, bp_sat_ctr (CTR_W param, inc/dec/hold, saturating).

Verification (N=32, ENTRIES=16, CTR_W=2)
REQ-022 After reset, lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x41.
REQ-023 Update 0x40 taken target 0x10; next cycle lookup 0x40 -> hit=1, taken=1, target=0x10; upd_mispredict was 1 on the update.
REQ-024 Then not-taken updates on 0x40: ctr 10->01 (taken=0, target 0x41)->00->00 (saturate); one taken update -> 01, still predicts not taken.
REQ-025 Alias: 0x40 entry present, taken update on 0x50 target 0x20 -> 0x50 hits to 0x20, 0x40 misses; not-taken update on 0x60 leaves 0x50 entry intact.
REQ-026 flush and upd_valid (0x70 taken) same cycle -> next cycle every lookup misses, including 0x70; rst with pending update -> entry not written.
REQ-027 With BP_STATS_EN: 5 cycles after reset with 1 mispredicting update -> stat_lookups=5, stat_mispredicts=1; forced to 0xFFFFFFFF holds on further increments.
